// File: rtl/magma_ecb_sequencer_if.sv
// Bundle between the key/data entry driver (master) and the Magma ECB sequencer (slave).
interface magma_ecb_sequencer_if #(
  parameter int NBLK = 2
);
  localparam int DW = 64 * NBLK;

  logic          start;
  logic          decrypt;
  logic [255:0]  key;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic [4:0]    round;

  modport master (
    output start, decrypt, key, data_in,
    input  data_out, busy, done, round
  );

  modport slave (
    input  start, decrypt, key, data_in,
    output data_out, busy, done, round
  );
endinterface

// File: rtl/magma_ecb_sequencer.sv
// Magma (GOST R 34.12-2015) ECB sequencer: one Feistel round per clock over an
// NBLK-block buffer, with per-block write-back into data_out.
module magma_ecb_sequencer #(
  parameter int NBLK = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  magma_ecb_sequencer_if.slave bus
);
  localparam int DW = 64 * NBLK;
  localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);

  // id-tc26-Z S-boxes, row j serves nibble j; entry x sits at bits [63-4x -: 4].
  localparam logic [0:7][63:0] SBOX = {
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_STORE,
    S_DONE
  } state_t;

  state_t        state_reg;
  logic [255:0]  key_reg;
  logic [DW-1:0] data_reg;
  logic [DW-1:0] data_out_reg;
  logic          decrypt_reg;
  logic [BW-1:0] blk_reg;
  logic [4:0]    round_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [31:0]   a1_reg;
  logic [31:0]   a0_reg;

  logic [31:0]   key_word [8];
  logic [2:0]    key_idx;
  logic [31:0]   sum;
  logic [31:0]   sub;
  logic [31:0]   g_out;

  genvar gi;

  for (gi = 0; gi < 8; gi++) begin : g_key
    assign key_word[gi] = key_reg[255 - 32*gi -: 32];
  end

  // Ascending K1..K8 for the first passes, descending for the tail; decrypt has one ascending pass.
  always_comb begin
    key_idx = round_reg[2:0];
    if (decrypt_reg ? (round_reg >= 5'd8) : (round_reg >= 5'd24))
      key_idx = ~round_reg[2:0];
  end

  assign sum = a0_reg + key_word[key_idx];

  for (gi = 0; gi < 8; gi++) begin : g_sbox
    localparam logic [63:0] ROW = SBOX[gi];
    logic [3:0] nib;
    assign nib                = sum[4*gi +: 4];
    assign sub[4*gi +: 4]     = ROW[{~nib, 2'b00} +: 4];
  end

  assign g_out = {sub[20:0], sub[31:21]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      key_reg      <= '0;
      data_reg     <= '0;
      data_out_reg <= '0;
      decrypt_reg  <= 1'b0;
      blk_reg      <= '0;
      round_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      a1_reg       <= '0;
      a0_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            key_reg     <= bus.key;
            data_reg    <= bus.data_in;
            decrypt_reg <= bus.decrypt;
            blk_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= S_LOAD;
          end
        end
        S_LOAD: begin
          {a1_reg, a0_reg} <= data_reg[{blk_reg, 6'd0} +: 64];
          round_reg        <= '0;
          state_reg        <= S_ROUND;
        end
        S_ROUND: begin
          a1_reg    <= a0_reg;
          a0_reg    <= g_out ^ a1_reg;
          round_reg <= round_reg + 5'd1;
          if (round_reg == 5'd31)
            state_reg <= S_STORE;
        end
        S_STORE: begin
          // Swapping the halves back undoes the exchange of the last round.
          data_out_reg[{blk_reg, 6'd0} +: 64] <= {a0_reg, a1_reg};
          blk_reg <= blk_reg + 1'b1;
          if (blk_reg == LAST_BLK) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            state_reg <= S_LOAD;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.round    = round_reg;
endmodule

// File: tb/tb_magma_ecb_sequencer.sv
// Directed and randomized checks of magma_ecb_sequencer against a software Magma model.
module tb_magma_ecb_sequencer;
  localparam int MAXC = 150;
  localparam logic [255:0] KEY_A =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0] PT = 64'hfedcba9876543210;
  localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [4:0]   rnd_tr  [0:MAXC+1];
  logic         busy_tr [0:MAXC+1];
  logic         done_tr [0:MAXC+1];
  logic [127:0] dout_tr [0:MAXC+1];

  int pi_tab [8][16] = '{
    '{12, 4, 6, 2, 10, 5, 11, 9, 14, 8, 13, 7, 0, 3, 15, 1},
    '{6, 8, 2, 3, 9, 10, 5, 12, 1, 14, 4, 7, 11, 13, 0, 15},
    '{11, 3, 5, 8, 2, 15, 10, 13, 14, 1, 7, 4, 12, 9, 6, 0},
    '{12, 8, 2, 1, 13, 4, 15, 6, 7, 0, 10, 5, 3, 14, 9, 11},
    '{7, 15, 5, 10, 8, 1, 6, 13, 0, 9, 3, 14, 11, 4, 2, 12},
    '{5, 13, 15, 6, 9, 2, 12, 10, 11, 7, 8, 1, 4, 3, 14, 0},
    '{8, 14, 2, 5, 6, 9, 1, 12, 15, 4, 11, 0, 13, 10, 3, 7},
    '{1, 7, 14, 13, 0, 5, 8, 3, 4, 15, 10, 6, 9, 12, 11, 2}
  };

  magma_ecb_sequencer_if #(.NBLK(2)) bus ();

  magma_ecb_sequencer #(.NBLK(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_g(input logic [31:0] k, input logic [31:0] a);
    logic [31:0] t;
    logic [31:0] s;
    t = a + k;
    for (int j = 0; j < 8; j++)
      s[4*j +: 4] = 4'(pi_tab[j][t[4*j +: 4]]);
    return (s << 11) | (s >> 21);
  endfunction

  // Straight transcription of the reference: 31 swapping rounds then G* without swap.
  function automatic logic [63:0] mdl_block(input logic [255:0] k, input logic [63:0] blk,
                                            input logic dec);
    logic [31:0] rk_enc [32];
    logic [31:0] rk [32];
    logic [31:0] a1;
    logic [31:0] a0;
    logic [31:0] tmp;
    for (int i = 0; i < 32; i++) begin
      int j;
      j = (i < 24) ? (i % 8) : (31 - i);
      rk_enc[i] = 32'(k >> (224 - 32*j));
    end
    for (int i = 0; i < 32; i++)
      rk[i] = dec ? rk_enc[31-i] : rk_enc[i];
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 31; i++) begin
      tmp = a0;
      a0  = mdl_g(rk[i], a0) ^ a1;
      a1  = tmp;
    end
    return {mdl_g(rk[31], a0) ^ a1, a0};
  endfunction

  function automatic logic [127:0] mdl_buf(input logic [255:0] k, input logic [127:0] d,
                                           input logic dec);
    return {mdl_block(k, d[127:64], dec), mdl_block(k, d[63:0], dec)};
  endfunction

  function automatic int busy_errs(input int last);
    int n;
    n = 0;
    for (int c = 1; c <= last; c++)
      if (busy_tr[c] !== (c <= 68)) n++;
    return n;
  endfunction

  task automatic rec(input int c);
    rnd_tr[c]  = bus.round;
    busy_tr[c] = bus.busy;
    done_tr[c] = bus.done;
    dout_tr[c] = bus.data_out;
  endtask

  // Cycle c is the clock period after the c-th edge following the start edge (start edge = cycle 1 begins).
  task automatic run_op(input logic [255:0] k, input logic [127:0] d, input logic dec,
                        input bit noisy, output int dcyc);
    int c;
    dcyc = 0;
    @(posedge clk); #1;
    bus.key     = k;
    bus.data_in = d;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    rec(c);
    while (dcyc == 0 && c < MAXC) begin
      if (bus.done) begin
        dcyc = c;
      end else begin
        if (noisy && (c == 10 || c == 68)) begin
          bus.start   = 1'b1;
          bus.key     = ~bus.key;
          bus.data_in = ~bus.data_in;
          bus.decrypt = ~bus.decrypt;
        end else begin
          bus.start = 1'b0;
        end
        @(posedge clk); #1;
        c++;
        rec(c);
      end
    end
    bus.start = noisy;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c++;
    rec(c);
    $display("op %s key=%h din=%h dout=%h done_cycle=%0d", dec ? "dec" : "enc", k, d,
             bus.data_out, dcyc);
  endtask

  initial begin
    int           dc;
    int           ndone;
    logic [255:0] rk;
    logic [127:0] rd;
    logic [127:0] ct;
    logic [127:0] exp3;

    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    bus.key     = '0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check_val("rst_dout", bus.data_out, 128'd0);
    check_val("rst_busy", 128'(bus.busy), 128'd0);
    check_val("rst_done", 128'(bus.done), 128'd0);
    check_val("rst_round", 128'(bus.round), 128'd0);
    check_val("model_kat", 128'(mdl_block(KEY_A, PT, 1'b0)), 128'(CT));

    // 1: known-answer encrypt, latency and status timing
    run_op(KEY_A, {PT, PT}, 1'b0, 1'b0, dc);
    check_val("s1_latency", 128'(dc), 128'd69);
    check_val("s1_dout", bus.data_out, {CT, CT});
    check_val("s1_busy_window", 128'(busy_errs(70)), 128'd0);
    check_val("s1_done_pulse", 128'(done_tr[70]), 128'd0);
    check_val("s1_round_load", 128'(rnd_tr[1]), 128'd0);
    check_val("s1_round_r1", 128'(rnd_tr[3]), 128'd1);
    check_val("s1_round_r31", 128'(rnd_tr[33]), 128'd31);
    check_val("s1_round_store", 128'(rnd_tr[34]), 128'd0);

    // 2: known-answer decrypt
    run_op(KEY_A, {CT, CT}, 1'b1, 1'b0, dc);
    check_val("s2_latency", 128'(dc), 128'd69);
    check_val("s2_dout", bus.data_out, {PT, PT});

    // 3: distinct blocks and per-half write-back timing
    exp3 = {CT, mdl_block(KEY_A, CT, 1'b0)};
    run_op(KEY_A, {PT, CT}, 1'b0, 1'b0, dc);
    check_val("s3_lo_c34", 128'(dout_tr[34][63:0]), 128'(PT));
    check_val("s3_lo_c35", 128'(dout_tr[35][63:0]), 128'(exp3[63:0]));
    check_val("s3_hi_c68", 128'(dout_tr[68][127:64]), 128'(PT));
    check_val("s3_dout_c69", dout_tr[69], exp3);
    check_val("s3_latency", 128'(dc), 128'd69);

    // 4: start pulses and input changes mid-run are ignored
    run_op(KEY_A, {PT, PT}, 1'b0, 1'b1, dc);
    check_val("s4_latency", 128'(dc), 128'd69);
    check_val("s4_dout", bus.data_out, {CT, CT});
    check_val("s4_busy_window", 128'(busy_errs(70)), 128'd0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check_val("s4_no_rerun", 128'(ndone), 128'd0);

    // 5: reset mid-run aborts and clears
    @(posedge clk); #1;
    bus.key     = KEY_A;
    bus.data_in = {PT, PT};
    bus.decrypt = 1'b0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (39) begin
      @(posedge clk); #1;
    end
    check_val("s5_pre_lo", 128'(bus.data_out[63:0]), 128'(CT));
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_val("s5_dout", bus.data_out, 128'd0);
    check_val("s5_busy", 128'(bus.busy), 128'd0);
    check_val("s5_round", 128'(bus.round), 128'd0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check_val("s5_no_done", 128'(ndone), 128'd0);
    run_op(KEY_A, {PT, PT}, 1'b0, 1'b0, dc);
    check_val("s5_rerun_latency", 128'(dc), 128'd69);
    check_val("s5_rerun_dout", bus.data_out, {CT, CT});

    // 6: random keys/data, encrypt vs model then decrypt round-trip
    for (int n = 0; n < 100; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_op(rk, rd, 1'b0, 1'b0, dc);
      check_val("rnd_enc", bus.data_out, mdl_buf(rk, rd, 1'b0));
      check_val("rnd_enc_latency", 128'(dc), 128'd69);
      ct = bus.data_out;
      run_op(rk, ct, 1'b1, 1'b0, dc);
      check_val("rnd_dec", bus.data_out, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
